// File: rtl/rep_code_pkg.sv
// rep_code_pkg: shared FSM states, default sizes and parity helper for the repetition-coded link (REP_PARITY_EN adds the PARITY state)
package rep_code_pkg;
    localparam int REP_DEF    = 5;
    localparam int DATA_W_DEF = 8;
`ifdef REP_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/rep_chip_counter.sv
// rep_chip_counter: counts REP chips on en and pulses wrap while the last chip of a bit is consumed
module rep_chip_counter
    import rep_code_pkg::*;
#(
    parameter int REP = REP_DEF,
    localparam int CW = $clog2(REP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap
);
    assign wrap = en && cnt == CW'(REP - 1);
    // chip position within the current bit; cleared when a new word starts
    always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/rep_serial_encoder.sv
// rep_serial_encoder: LSB-first serial repetition-code transmitter; REP_PARITY_EN appends an even-parity bit
module rep_serial_encoder
    import rep_code_pkg::*;
#(
    parameter int   DATA_W   = DATA_W_DEF,
    parameter int   REP      = REP_DEF,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              chip_en,
    output logic              tx_out,
    output logic              tx_valid,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              busy
);
    localparam int CW = $clog2(REP);
    localparam int BW = $clog2(DATA_W + 1);
    state_t            state, state_nx;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [CW-1:0]     chip_cnt;
    logic              wrap, accept, last_bit, last_chip;
`ifdef REP_PARITY_EN
    logic              par;
`endif
    assign accept    = din_valid && state == IDLE;
    assign last_bit  = bit_cnt == BW'(DATA_W - 1);
    assign last_chip = chip_cnt == CW'(REP - 1);
    rep_chip_counter #(.REP(REP)) u_chip_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .en   (chip_en && state != IDLE),
        .cnt  (chip_cnt),
        .wrap (wrap)
    );
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // next state: a frame advances only on consumed chips
    always_comb begin
        state_nx = state;
        if (state == IDLE && din_valid) state_nx = DATA;
`ifdef REP_PARITY_EN
        else if (state == DATA && wrap && last_bit) state_nx = PARITY;
        else if (state == PARITY && wrap) state_nx = IDLE;
`else
        else if (state == DATA && wrap && last_bit) state_nx = IDLE;
`endif
    end
    // word capture at accept, one-bit shift per completed bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef REP_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (accept) begin
            shreg   <= din;
            bit_cnt <= '0;
`ifdef REP_PARITY_EN
            par     <= even_parity(64'(din));
`endif
        end else if (state == DATA && wrap) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end
    assign busy      = state != IDLE;
    assign din_ready = state == IDLE;
    assign tx_valid  = busy;
    assign tx_sof    = state == DATA && bit_cnt == '0 && chip_cnt == '0;
`ifdef REP_PARITY_EN
    assign tx_out    = state == DATA ? shreg[0] : state == PARITY ? par : IDLE_LVL;
    assign tx_eof    = state == PARITY && last_chip;
`else
    assign tx_out    = state == DATA ? shreg[0] : IDLE_LVL;
    assign tx_eof    = state == DATA && last_bit && last_chip;
`endif
endmodule

// File: tb/tb_rep_serial_encoder.sv
// tb_rep_serial_encoder: scoreboard bench for rep_serial_encoder (default and REP=3/DATA_W=4 instances; honours REP_PARITY_EN)
module tb_rep_serial_encoder;
    localparam int DW = 8;
    localparam int R  = 5;
`ifdef REP_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L  = (DW + PAR) * R;
    localparam int LS = (4 + PAR) * 3;

    typedef struct {
        logic v;
        logic sof;
        logic eof;
    } chip_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [DW-1:0] din;
    logic din_valid, din_ready, chip_en, tx_out, tx_valid, tx_sof, tx_eof, busy;
    logic [3:0] s_din;
    logic s_valid, s_ready, s_en, s_out, s_txv, s_sof, s_eof, s_busy;

    int n_assert = 0;
    int n_fail = 0;
    chip_t sb[$];
    logic prev_hold = 1'b0;
    logic p_out, p_sof, p_eof, p_valid;

    always #5 clk = ~clk;

    rep_serial_encoder #(.DATA_W(DW), .REP(R), .IDLE_LVL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .chip_en(chip_en), .tx_out(tx_out), .tx_valid(tx_valid), .tx_sof(tx_sof),
        .tx_eof(tx_eof), .busy(busy)
    );

    rep_serial_encoder #(.DATA_W(4), .REP(3), .IDLE_LVL(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .din(s_din), .din_valid(s_valid), .din_ready(s_ready),
        .chip_en(s_en), .tx_out(s_out), .tx_valid(s_txv), .tx_sof(s_sof),
        .tx_eof(s_eof), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [DW-1:0] w);
        chip_t e;
        for (int i = 0; i < DW; i++)
            for (int c = 0; c < R; c++) begin
                e.v   = w[i];
                e.sof = (i == 0 && c == 0);
                e.eof = (PAR == 0 && i == DW - 1 && c == R - 1);
                sb.push_back(e);
            end
        if (PAR != 0)
            for (int c = 0; c < R; c++) begin
                e.v   = ^w;
                e.sof = 1'b0;
                e.eof = (c == R - 1);
                sb.push_back(e);
            end
    endtask

    function automatic logic [14:0] small_model(input logic [3:0] w);
        logic [14:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 3; c++) r[i*3+c] = w[i];
        if (PAR != 0)
            for (int c = 0; c < 3; c++) r[12+c] = ^w;
        return r;
    endfunction

    task automatic send(input logic [DW-1:0] w);
        din = w;
        din_valid = 1'b1;
        push_frame(w);
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic run_frame(input int period, input int pulse_at);
        int k;
        for (k = 0; k < 2000; k++) begin
            chip_en = (k % period) == period - 1;
            if (k == pulse_at) begin
                din = 8'hFF;
                din_valid = 1'b1;
            end else if (k == pulse_at + 1) din_valid = 1'b0;
            @(negedge clk);
            if (!busy) break;
            if (k == pulse_at) chk("ready_in_frame", din_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        chk("frame_cycles", k, L * period);
        chk("end_ready", din_ready, 1'b1);
        chk("end_valid", tx_valid, 1'b0);
        chk("end_out", tx_out, 1'b0);
        chk("sb_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // scoreboard pop on every consumed chip, and hold check across chip_en-low cycles
    always @(negedge clk) begin
        if (prev_hold) begin
            chk("hold_out", tx_out, p_out);
            chk("hold_sof", tx_sof, p_sof);
            chk("hold_eof", tx_eof, p_eof);
            chk("hold_valid", tx_valid, p_valid);
        end
        if (rst_n && tx_valid && chip_en) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed queue size 0 expected >0");
            end
            if (sb.size() > 0) begin
                chk("chip_val", tx_out, sb[0].v);
                chk("chip_sof", tx_sof, sb[0].sof);
                chk("chip_eof", tx_eof, sb[0].eof);
                void'(sb.pop_front());
            end
        end
        prev_hold = rst_n && tx_valid && !chip_en;
        p_out = tx_out;
        p_sof = tx_sof;
        p_eof = tx_eof;
        p_valid = tx_valid;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [14:0] got;
        rst_n = 1'b0;
        din = '0;
        din_valid = 1'b0;
        chip_en = 1'b0;
        s_din = '0;
        s_valid = 1'b0;
        s_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", din_ready, 1'b1);
        chk("rst_out", tx_out, 1'b0);
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_sof", tx_sof, 1'b0);
        chk("rst_eof", tx_eof, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chip_en = 1'b1;
        send(8'hA5);
        run_frame(1, -1);
        send(8'h01);
        run_frame(3, -1);
        send(8'h00);
        run_frame(1, 10);
        send(8'h3C);
        chip_en = 1'b1;
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_valid", tx_valid, 1'b0);
        chk("abort_out", tx_out, 1'b0);
        chk("abort_ready", din_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h96);
        run_frame(1, -1);
        send(8'h07);
        run_frame(1, -1);
        s_din = 4'b1010;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_din = 4'b0101;
        got = '0;
        for (int i = 0; i < LS; i++) begin
            @(negedge clk);
            got[i] = s_out;
            chk("s1_valid", s_txv, 1'b1);
            chk("s1_sof", s_sof, i == 0);
            chk("s1_eof", s_eof, i == LS - 1);
        end
        chk("s1_chips", got, small_model(4'b1010));
        @(negedge clk);
        chk("s_gap_valid", s_txv, 1'b0);
        chk("s_gap_ready", s_ready, 1'b1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        got = '0;
        for (int i = 0; i < LS; i++) begin
            @(negedge clk);
            got[i] = s_out;
            chk("s2_valid", s_txv, 1'b1);
            chk("s2_sof", s_sof, i == 0);
        end
        chk("s2_chips", got, small_model(4'b0101));
        @(negedge clk);
        chk("s_end_valid", s_txv, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
